// File: rtl/vlsu_shuffle_fifo_unit.sv
// VLSU load shuffler: permutes sequential load beats into per-lane VRF order,
// applies the mask and queues the result in independent per-lane FIFOs.

module vlsu_shf_lane_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned EntW  = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [EntW-1:0] data_i,
  input  logic            pop_i,
  output logic            valid_o,
  output logic            space_o,
  output logic [EntW-1:0] data_o
);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [EntW-1:0] mem_q [Depth];
  logic [EntW-1:0] mem_d [Depth];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid_o = (cnt_q != '0);
  assign space_o = (cnt_q < CW'(Depth));
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = data_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module vlsu_shuffle_fifo_unit #(
  parameter int unsigned NrLanes    = 4,
  parameter int unsigned NbPerLane  = 16,
  parameter int unsigned ShfBufDep  = 2,
  parameter int unsigned ShfInfoDep = 4,
  parameter int unsigned SetBits    = 6,
  parameter int unsigned BankBits   = 2,
  parameter int unsigned ReqIdBits  = 4,
  parameter int unsigned CmtCntBits = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   meta_valid_i,
  output logic                                   meta_ready_o,
  input  logic [ReqIdBits-1:0]                   meta_req_id_i,
  input  logic                                   meta_mode_i,
  input  logic [1:0]                             meta_sew_i,
  input  logic                                   meta_vm_i,
  input  logic [SetBits-1:0]                     meta_vset_i,
  input  logic [BankBits-1:0]                    meta_vbank_i,
  input  logic [CmtCntBits-1:0]                  meta_cmt_cnt_i,
  input  logic                                   seq_valid_i,
  output logic                                   seq_ready_o,
  input  logic [NrLanes*NbPerLane-1:0][3:0]      seq_nb_i,
  input  logic [NrLanes*NbPerLane-1:0]           seq_en_i,
  input  logic                                   mask_valid_i,
  input  logic [NrLanes*NbPerLane-1:0]           mask_bits_i,
  output logic                                   mask_ready_o,
  output logic [NrLanes-1:0]                     txs_valid_o,
  input  logic [NrLanes-1:0]                     txs_ready_i,
  output logic [NrLanes-1:0][NbPerLane*4-1:0]    txs_data_o,
  output logic [NrLanes-1:0][NbPerLane-1:0]      txs_nbe_o,
  output logic [NrLanes-1:0][ReqIdBits-1:0]      txs_req_id_o,
  output logic [NrLanes-1:0][SetBits-1:0]        txs_vset_o,
  output logic [NrLanes-1:0][BankBits-1:0]       txs_vbank_o,
  output logic                                   idle_o
);
  localparam int unsigned NW = $clog2(NrLanes * NbPerLane);
  localparam int unsigned IW = $clog2(ShfInfoDep);

  typedef struct packed {
    logic [ReqIdBits-1:0]  req_id;
    logic                  mode;
    logic [1:0]            sew;
    logic                  vm;
    logic [SetBits-1:0]    vset;
    logic [BankBits-1:0]   vbank;
    logic [CmtCntBits-1:0] cmt_cnt;
  } info_t;

  typedef struct packed {
    logic [NbPerLane-1:0][3:0] data;
    logic [NbPerLane-1:0]      nbe;
    logic [ReqIdBits-1:0]      req_id;
    logic [SetBits-1:0]        vset;
    logic [BankBits-1:0]       vbank;
  } lane_ent_t;

  localparam int unsigned EntW = $bits(lane_ent_t);

  // Standard order: element e lands in lane e%NrLanes, slot e/NrLanes.
  function automatic logic [NW-1:0] query_seq_idx(input int unsigned shf, input logic [1:0] sew);
    int unsigned sh, lane, off, slot;
    sh   = 32'(sew) + 1;
    lane = shf / NbPerLane;
    off  = shf % NbPerLane;
    slot = off >> sh;
    return NW'((((slot * NrLanes) + lane) << sh) + (off & ((32'd1 << sh) - 1)));
  endfunction

  // 2D-column order: lane assignment skewed by the slot index so successive
  // column elements rotate across lanes.
  function automatic logic [NW-1:0] query_seq_idx_2d_cln(input int unsigned shf, input logic [1:0] sew);
    int unsigned sh, lane, off, slot;
    sh   = 32'(sew) + 1;
    lane = shf / NbPerLane;
    off  = shf % NbPerLane;
    slot = off >> sh;
    return NW'((((slot * NrLanes) + ((lane + slot) % NrLanes)) << sh) + (off & ((32'd1 << sh) - 1)));
  endfunction

  info_t        info_q [ShfInfoDep];
  info_t        info_d [ShfInfoDep];
  logic [IW:0]  enq_q, enq_d, deq_q, deq_d;
  info_t        head, meta_in;
  logic         info_empty, info_full, enq, commit;

  lane_ent_t [NrLanes-1:0] shf_ent;
  lane_ent_t [NrLanes-1:0] lane_out;
  logic      [NrLanes-1:0] lane_space;

  assign info_empty = (enq_q == deq_q);
  assign info_full  = (enq_q[IW] != deq_q[IW]) && (enq_q[IW-1:0] == deq_q[IW-1:0]);
  assign head       = info_q[deq_q[IW-1:0]];

  assign meta_ready_o = !info_full;
  assign seq_ready_o  = !flush_i && !info_empty && (&lane_space) && (head.vm || mask_valid_i);
  assign commit       = seq_valid_i && seq_ready_o;
  assign mask_ready_o = commit && !head.vm;
  assign enq          = meta_valid_i && !info_full && !flush_i;

  always_comb begin
    meta_in = '{req_id: meta_req_id_i, mode: meta_mode_i, sew: meta_sew_i, vm: meta_vm_i,
                vset: meta_vset_i, vbank: meta_vbank_i, cmt_cnt: meta_cmt_cnt_i};
  end

  always_comb begin
    info_d = info_q;
    enq_d  = enq_q;
    deq_d  = deq_q;
    if (flush_i) begin
      enq_d = '0;
      deq_d = '0;
    end else begin
      if (commit) begin
        if (head.cmt_cnt == '0) begin
          deq_d = deq_q + 1'b1;
        end else begin
          info_d[deq_q[IW-1:0]].vset    = head.vset + SetBits'(1);
          info_d[deq_q[IW-1:0]].cmt_cnt = head.cmt_cnt - CmtCntBits'(1);
        end
      end
      // A non-full, non-empty queue never has its enq slot on the head.
      if (enq) begin
        info_d[enq_q[IW-1:0]] = meta_in;
        enq_d                 = enq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(ShfInfoDep); i++) info_q[i] <= '0;
      enq_q <= '0;
      deq_q <= '0;
    end else begin
      info_q <= info_d;
      enq_q  <= enq_d;
      deq_q  <= deq_d;
    end
  end

  always_comb begin
    shf_ent = '0;
    for (int unsigned l = 0; l < NrLanes; l++) begin
      for (int unsigned o = 0; o < NbPerLane; o++) begin
        int unsigned  shf;
        logic [NW-1:0] src;
        shf = l * NbPerLane + o;
        src = head.mode ? query_seq_idx_2d_cln(shf, head.sew) : query_seq_idx(shf, head.sew);
        shf_ent[l].data[o] = seq_nb_i[src];
        shf_ent[l].nbe[o]  = seq_en_i[src] && (head.vm || mask_bits_i[NW'(shf)]);
      end
      shf_ent[l].req_id = head.req_id;
      shf_ent[l].vset   = head.vset;
      shf_ent[l].vbank  = head.vbank;
    end
  end

  vlsu_shf_lane_fifo #(.Depth(ShfBufDep), .EntW(EntW)) u_lane_fifo [NrLanes-1:0] (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (commit),
    .data_i  (shf_ent),
    .pop_i   (txs_ready_i),
    .valid_o (txs_valid_o),
    .space_o (lane_space),
    .data_o  (lane_out)
  );

  always_comb begin
    for (int l = 0; l < int'(NrLanes); l++) begin
      txs_data_o[l]   = lane_out[l].data;
      txs_nbe_o[l]    = lane_out[l].nbe;
      txs_req_id_o[l] = lane_out[l].req_id;
      txs_vset_o[l]   = lane_out[l].vset;
      txs_vbank_o[l]  = lane_out[l].vbank;
    end
  end

  assign idle_o = info_empty && !(|txs_valid_o);

`ifndef SYNTHESIS
  a_seq_needs_info: assert property (@(posedge clk_i) disable iff (!rst_ni) seq_valid_i |-> !info_empty)
    else $error("sequential beat offered with an empty info queue");
`endif
endmodule

// File: tb/tb_vlsu_shuffle_fifo_unit.sv
// Randomized self-checking bench for vlsu_shuffle_fifo_unit against a
// queue-based reference model (forward scatter of sequential nibbles).

module tb_vlsu_shuffle_fifo_unit;
  localparam int NL = 4, NB = 16, DEP = 2, IDEP = 4;
  localparam int SB = 6, BB = 2, RB = 4, CB = 8;
  localparam int NN = NL * NB;

  typedef struct {
    logic [RB-1:0] req;
    logic          mode;
    logic [1:0]    sew;
    logic          vm;
    logic [SB-1:0] vset;
    logic [BB-1:0] vbank;
    logic [CB-1:0] cmt;
  } minfo_t;

  typedef struct {
    logic [NB*4-1:0] data;
    logic [NB-1:0]   nbe;
    logic [RB-1:0]   req;
    logic [SB-1:0]   vset;
    logic [BB-1:0]   vbank;
  } ment_t;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic            flush, meta_valid, seq_valid, mask_valid;
  minfo_t          mi;
  logic [NN*4-1:0] seq_nb;
  logic [NN-1:0]   seq_en, mask_bits;
  logic [NL-1:0]   txs_ready;

  logic                     meta_ready, seq_ready, mask_ready, idle;
  logic [NL-1:0]            txs_valid;
  logic [NL-1:0][NB*4-1:0]  txs_data;
  logic [NL-1:0][NB-1:0]    txs_nbe;
  logic [NL-1:0][RB-1:0]    txs_req;
  logic [NL-1:0][SB-1:0]    txs_vset;
  logic [NL-1:0][BB-1:0]    txs_vbank;

  vlsu_shuffle_fifo_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .meta_valid_i(meta_valid), .meta_ready_o(meta_ready),
    .meta_req_id_i(mi.req), .meta_mode_i(mi.mode), .meta_sew_i(mi.sew), .meta_vm_i(mi.vm),
    .meta_vset_i(mi.vset), .meta_vbank_i(mi.vbank), .meta_cmt_cnt_i(mi.cmt),
    .seq_valid_i(seq_valid), .seq_ready_o(seq_ready), .seq_nb_i(seq_nb), .seq_en_i(seq_en),
    .mask_valid_i(mask_valid), .mask_bits_i(mask_bits), .mask_ready_o(mask_ready),
    .txs_valid_o(txs_valid), .txs_ready_i(txs_ready), .txs_data_o(txs_data), .txs_nbe_o(txs_nbe),
    .txs_req_id_o(txs_req), .txs_vset_o(txs_vset), .txs_vbank_o(txs_vbank), .idle_o(idle)
  );

  int     n_checks = 0, n_err = 0;
  minfo_t iq[$];
  ment_t  lq[NL][$];

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scatter every sequential nibble to its (lane, offset) destination.
  task automatic model_shuffle(input minfo_t h, output logic [NL-1:0][NB*4-1:0] d,
                               output logic [NL-1:0][NB-1:0] e);
    int ew, el, n, slot, r, lane, off;
    ew = 2 << h.sew;
    d = '0;
    e = '0;
    for (int s = 0; s < NN; s++) begin
      el   = s / ew;
      n    = s % ew;
      slot = el / NL;
      r    = el % NL;
      lane = h.mode ? ((r - slot) % NL + NL) % NL : r;
      off  = slot * ew + n;
      d[lane][off*4 +: 4] = seq_nb[s*4 +: 4];
      e[lane][off]        = seq_en[s] && (h.vm || mask_bits[lane*NB + off]);
    end
  endtask

  function automatic bit lanes_empty();
    for (int l = 0; l < NL; l++) if (lq[l].size() != 0) return 0;
    return 1;
  endfunction

  function automatic bit lanes_space();
    for (int l = 0; l < NL; l++) if (lq[l].size() >= DEP) return 0;
    return 1;
  endfunction

  // Compare current outputs with the model, advance the model by one clock.
  task automatic step();
    logic exp_sr, exp_mr, commit;
    logic [NL-1:0] pops;
    logic [NL-1:0][NB*4-1:0] d;
    logic [NL-1:0][NB-1:0] e;
    minfo_t h;
    ment_t ent;
    #1;
    exp_sr = !flush && iq.size() > 0 && lanes_space() && (iq.size() > 0 && (iq[0].vm || mask_valid));
    exp_mr = iq.size() < IDEP;
    commit = seq_valid && exp_sr;
    chk("seq_ready", 256'(seq_ready), 256'(exp_sr));
    chk("mask_ready", 256'(mask_ready), 256'(commit && !iq[0].vm));
    chk("meta_ready", 256'(meta_ready), 256'(exp_mr));
    chk("idle", 256'(idle), 256'(iq.size() == 0 && lanes_empty()));
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("valid%0d", l), 256'(txs_valid[l]), 256'(lq[l].size() != 0));
      if (lq[l].size() != 0) begin
        chk($sformatf("data%0d", l), 256'(txs_data[l]), 256'(lq[l][0].data));
        chk($sformatf("nbe%0d", l), 256'(txs_nbe[l]), 256'(lq[l][0].nbe));
        chk($sformatf("tag%0d", l), 256'({txs_req[l], txs_vset[l], txs_vbank[l]}),
            256'({lq[l][0].req, lq[l][0].vset, lq[l][0].vbank}));
      end
    end
    if (flush) begin
      iq.delete();
      for (int l = 0; l < NL; l++) lq[l].delete();
    end else begin
      for (int l = 0; l < NL; l++) pops[l] = lq[l].size() > 0 && txs_ready[l];
      if (commit) begin
        h = iq[0];
        model_shuffle(h, d, e);
        for (int l = 0; l < NL; l++) begin
          ent.data = d[l]; ent.nbe = e[l]; ent.req = h.req; ent.vset = h.vset; ent.vbank = h.vbank;
          lq[l].push_back(ent);
        end
        if (h.cmt == 0) void'(iq.pop_front());
        else begin
          h.vset = h.vset + 1'b1;
          h.cmt  = h.cmt - 1'b1;
          iq[0]  = h;
        end
      end
      for (int l = 0; l < NL; l++) if (pops[l]) void'(lq[l].pop_front());
      if (meta_valid && exp_mr) iq.push_back(mi);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_meta(input logic [RB-1:0] req, input logic mode, input logic [1:0] sew,
                          input logic vm, input logic [SB-1:0] vset, input logic [CB-1:0] cmt);
    mi.req = req; mi.mode = mode; mi.sew = sew; mi.vm = vm; mi.vset = vset;
    mi.vbank = BB'($urandom); mi.cmt = cmt;
  endtask

  task automatic rand_beat();
    seq_nb    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    seq_en    = {$urandom, $urandom};
    mask_bits = {$urandom, $urandom};
  endtask

  task automatic drain();
    seq_valid = 0; meta_valid = 0; mask_valid = 0; txs_ready = '1;
    repeat (DEP + 2) step();
    flush = 1;
    step();
    flush = 0;
  endtask

  initial begin
    flush = 0; meta_valid = 0; seq_valid = 0; mask_valid = 0; txs_ready = '1;
    seq_nb = '0; seq_en = '0; mask_bits = '0;
    set_meta(0, 0, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 256'(txs_valid), 256'(0));
    chk("rst_meta_ready", 256'(meta_ready), 256'(1));
    chk("rst_idle", 256'(idle), 256'(1));
    rst_n = 1;
    @(negedge clk);
    chk("rst_seq_ready", 256'(seq_ready), 256'(0));
    chk("rst_mask_ready", 256'(mask_ready), 256'(0));

    // single beat, standard order
    set_meta(3, 0, 0, 1, 5, 0); meta_valid = 1; step();
    meta_valid = 0; seq_valid = 1; rand_beat(); step();
    seq_valid = 0;
    chk("t1_valid", 256'(txs_valid), 256'(4'hF));
    chk("t1_vset", 256'(txs_vset[0]), 256'(5));
    step();
    chk("t1_idle", 256'(idle), 256'(1));
    drain();

    // lane 2 stalls, others drain
    set_meta(4, 0, 1, 1, 10, 2); meta_valid = 1; step();
    meta_valid = 0; txs_ready = 4'b1011; seq_valid = 1;
    rand_beat(); step();
    rand_beat(); step();
    chk("t2_blocked", 256'(seq_ready), 256'(0));
    step(); step();
    txs_ready = 4'b1111; step();
    chk("t2_resume", 256'(seq_ready), 256'(1));
    step();
    seq_valid = 0;
    drain();

    // masked request waits for mask
    set_meta(5, 0, 2, 0, 20, 0); meta_valid = 1; step();
    meta_valid = 0; seq_valid = 1; rand_beat(); seq_en = '1;
    repeat (3) begin
      #1 chk("t3_wait_mask", 256'(seq_ready), 256'(0));
      step();
    end
    mask_valid = 1; mask_bits = '0;
    #1 chk("t3_mask_ready", 256'(mask_ready), 256'(1));
    step();
    seq_valid = 0; mask_valid = 0;
    #1 chk("t3_mask_once", 256'(mask_ready), 256'(0));
    chk("t3_nbe", 256'(txs_nbe), 256'(0));
    drain();

    // vset wrap
    set_meta(6, 0, 3, 1, 63, 1); meta_valid = 1; step();
    meta_valid = 0; seq_valid = 1; rand_beat(); step();
    chk("t4_vset63", 256'(txs_vset[0]), 256'(63));
    rand_beat(); step();
    seq_valid = 0;
    chk("t4_vset0", 256'(txs_vset[1]), 256'(0));
    step();
    chk("t4_idle", 256'(idle), 256'(1));
    drain();

    // full info queue, enq with a final-beat commit
    for (int i = 0; i < IDEP; i++) begin
      set_meta(RB'(8 + i), (i == 1), 2'(i), 1, SB'(i * 3), 0); meta_valid = 1; step();
    end
    set_meta(12, 1, 0, 1, 33, 0); seq_valid = 1; rand_beat();
    #1 chk("t5_refused", 256'(meta_ready), 256'(0));
    step();
    seq_valid = 0;
    #1 chk("t5_accept", 256'(meta_ready), 256'(1));
    step();
    meta_valid = 0;
    for (int i = 0; i < 12 && iq.size() > 0; i++) begin
      seq_valid = 1; rand_beat(); step();
    end
    seq_valid = 0;
    drain();

    // flush with buffered beats and info entries
    for (int i = 0; i < 3; i++) begin
      set_meta(RB'(i), 0, 0, 1, 7, 3); meta_valid = 1; step();
    end
    meta_valid = 0; txs_ready = '0;
    repeat (2) begin seq_valid = 1; rand_beat(); step(); end
    flush = 1; meta_valid = 1; set_meta(9, 0, 0, 1, 1, 0);
    #1 chk("t6_seq_ready", 256'(seq_ready), 256'(0));
    step();
    flush = 0; seq_valid = 0; meta_valid = 0;
    chk("t6_valid", 256'(txs_valid), 256'(0));
    chk("t6_idle", 256'(idle), 256'(1));
    chk("t6_meta_ready", 256'(meta_ready), 256'(1));
    txs_ready = '1;

    // randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #3 rst_n = 0;
        #1;
        chk("arst_idle", 256'(idle), 256'(1));
        chk("arst_valid", 256'(txs_valid), 256'(0));
        iq.delete();
        for (int l = 0; l < NL; l++) lq[l].delete();
        seq_valid = 0; flush = 0; meta_valid = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
      end
      flush      = ($urandom_range(0, 39) == 0);
      meta_valid = ($urandom_range(0, 2) == 0);
      set_meta(RB'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), SB'($urandom),
               CB'($urandom_range(0, 3)));
      seq_valid  = (iq.size() > 0) && ($urandom_range(0, 3) != 0);
      mask_valid = ($urandom_range(0, 2) != 0);
      txs_ready  = NL'($urandom);
      rand_beat();
      step();
    end
    seq_valid = 0;
    drain();
    chk("end_idle", 256'(idle), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
